// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Execute stage placed after the register-file read. Runs
//                single-cycle ALU operations and an iterative shift-add MUL
//                that holds off upstream through O_ready. Produces a
//                registered result with destination and write enable for
//                the writeback path.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            I_rst,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [3:0]      I_aluop,
    input  logic [XLEN-1:0] I_dataA,
    input  logic [XLEN-1:0] I_dataB,
    input  logic [XLEN-1:0] I_imm,
    input  logic            I_useimm,
    input  logic [RA_W-1:0] I_rd,
    input  logic            I_regwe,
    output logic            O_valid,
    output logic [XLEN-1:0] O_result,
    output logic [RA_W-1:0] O_rd,
    output logic            O_regwe,
    output logic            O_zero
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_SLL   = 4'd5;
    localparam logic [3:0] c_OP_SRL   = 4'd6;
    localparam logic [3:0] c_OP_SRA   = 4'd7;
    localparam logic [3:0] c_OP_SLT   = 4'd8;
    localparam logic [3:0] c_OP_SLTU  = 4'd9;
    localparam logic [3:0] c_OP_MUL   = 4'd10;
    localparam logic [3:0] c_OP_PASSB = 4'd11;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    logic [0:0]      r_state;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [RA_W-1:0] r_rd;
    logic            r_regwe;
    logic            r_zero;

    // Multiplier working registers; rd/regwe are captured at accept so the
    // upstream may change its inputs while the MUL iterates.
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [RA_W-1:0] r_mul_rd;
    logic            r_mul_regwe;

    logic [XLEN-1:0] w_opb;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_legal;
    logic            w_accept;
    logic [XLEN-1:0] w_acc_next;

    assign O_ready  = (r_state == c_ST_IDLE);
    assign w_accept = I_valid && O_ready;
    assign w_opb    = I_useimm ? I_imm : I_dataB;
    assign w_shamt  = w_opb[4:0];
    assign w_legal  = (I_aluop <= c_OP_PASSB);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign O_valid  = r_valid;
    assign O_result = r_result;
    assign O_rd     = r_rd;
    assign O_regwe  = r_regwe;
    assign O_zero   = r_zero;

    // Single-cycle ALU result; MUL and illegal opcodes fall through to zero.
    always_comb begin
        w_alu = '0;
        case (I_aluop)
            c_OP_ADD:   w_alu = I_dataA + w_opb;
            c_OP_SUB:   w_alu = I_dataA - w_opb;
            c_OP_AND:   w_alu = I_dataA & w_opb;
            c_OP_OR:    w_alu = I_dataA | w_opb;
            c_OP_XOR:   w_alu = I_dataA ^ w_opb;
            c_OP_SLL:   w_alu = I_dataA << w_shamt;
            c_OP_SRL:   w_alu = I_dataA >> w_shamt;
            c_OP_SRA:   w_alu = XLEN'($signed(I_dataA) >>> w_shamt);
            c_OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(I_dataA) < $signed(w_opb))};
            c_OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (I_dataA < w_opb)};
            c_OP_PASSB: w_alu = w_opb;
            default:    w_alu = '0;
        endcase
    end

    // Control FSM, multiplier iteration and registered result outputs.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            r_state     <= c_ST_IDLE;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_regwe     <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_mul_rd    <= '0;
            r_mul_regwe <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_regwe <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (I_aluop == c_OP_MUL) begin
                            r_acc       <= '0;
                            r_mcand     <= I_dataA;
                            r_mplier    <= w_opb;
                            r_cnt       <= CNT_W'(XLEN-1);
                            r_mul_rd    <= I_rd;
                            r_mul_regwe <= I_regwe;
                            r_state     <= c_ST_MUL;
                        end else begin
                            r_valid  <= 1'b1;
                            r_result <= w_alu;
                            r_rd     <= I_rd;
                            r_regwe  <= I_regwe && w_legal && (I_rd != '0);
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
                c_ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_valid  <= 1'b1;
                        r_result <= w_acc_next;
                        r_rd     <= r_mul_rd;
                        r_regwe  <= r_mul_regwe && (r_mul_rd != '0);
                        r_zero   <= (w_acc_next == '0);
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Directed self-checking bench for alu_exec.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    logic        clk;
    logic        I_rst;
    logic        I_valid;
    logic        O_ready;
    logic [3:0]  I_aluop;
    logic [31:0] I_dataA;
    logic [31:0] I_dataB;
    logic [31:0] I_imm;
    logic        I_useimm;
    logic [4:0]  I_rd;
    logic        I_regwe;
    logic        O_valid;
    logic [31:0] O_result;
    logic [4:0]  O_rd;
    logic        O_regwe;
    logic        O_zero;

    int tests;
    int fails;

    alu_exec #(.XLEN(32), .RA_W(5)) dut (
        .clk      (clk),
        .I_rst    (I_rst),
        .I_valid  (I_valid),
        .O_ready  (O_ready),
        .I_aluop  (I_aluop),
        .I_dataA  (I_dataA),
        .I_dataB  (I_dataB),
        .I_imm    (I_imm),
        .I_useimm (I_useimm),
        .I_rd     (I_rd),
        .I_regwe  (I_regwe),
        .O_valid  (O_valid),
        .O_result (O_result),
        .O_rd     (O_rd),
        .O_regwe  (O_regwe),
        .O_zero   (O_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic useimm,
                         input logic [4:0] rd, input logic regwe);
        I_aluop  = op;
        I_dataA  = a;
        I_dataB  = b;
        I_imm    = imm;
        I_useimm = useimm;
        I_rd     = rd;
        I_regwe  = regwe;
        I_valid  = 1'b1;
        tick();
        I_valid  = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int vld_cnt;
        tests    = 0;
        fails    = 0;
        I_rst    = 1'b1;
        I_valid  = 1'b0;
        I_aluop  = 4'd0;
        I_dataA  = 32'd0;
        I_dataB  = 32'd0;
        I_imm    = 32'd0;
        I_useimm = 1'b0;
        I_rd     = 5'd0;
        I_regwe  = 1'b0;
        tick();
        tick();
        I_rst = 1'b0;

        // Reset state
        chk("rst_valid",  {31'd0, O_valid}, 32'd0);
        chk("rst_result", O_result,         32'd0);
        chk("rst_rd",     {27'd0, O_rd},    32'd0);
        chk("rst_regwe",  {31'd0, O_regwe}, 32'd0);
        chk("rst_zero",   {31'd0, O_zero},  32'd0);
        chk("rst_ready",  {31'd0, O_ready}, 32'd1);

        // 1: ADD with single-cycle pulse
        issue(4'd0, 32'd1000, 32'd10001, 32'd0, 1'b0, 5'd7, 1'b1);
        chk("add_valid",  {31'd0, O_valid}, 32'd1);
        chk("add_result", O_result,         32'd11001);
        chk("add_rd",     {27'd0, O_rd},    32'd7);
        chk("add_regwe",  {31'd0, O_regwe}, 32'd1);
        chk("add_zero",   {31'd0, O_zero},  32'd0);
        tick();
        chk("add_pulse_end", {31'd0, O_valid}, 32'd0);
        chk("add_hold",      O_result,         32'd11001);

        // 2: back-to-back ADD, SUB, SLT then SLTU
        I_aluop = 4'd0; I_dataA = 32'd1; I_dataB = 32'd2; I_useimm = 1'b0; I_rd = 5'd1; I_regwe = 1'b1;
        I_valid = 1'b1;
        tick();
        chk("b2b_add_valid",  {31'd0, O_valid}, 32'd1);
        chk("b2b_add_result", O_result,         32'd3);
        I_aluop = 4'd1; I_dataA = 32'd5; I_dataB = 32'd7; I_rd = 5'd2;
        tick();
        chk("b2b_sub_valid",  {31'd0, O_valid}, 32'd1);
        chk("b2b_sub_result", O_result,         32'hFFFF_FFFE);
        chk("b2b_sub_rd",     {27'd0, O_rd},    32'd2);
        I_aluop = 4'd8; I_dataA = 32'hFFFF_FFFE; I_dataB = 32'd1; I_rd = 5'd3;
        tick();
        I_valid = 1'b0;
        chk("b2b_slt_valid",  {31'd0, O_valid}, 32'd1);
        chk("b2b_slt_result", O_result,         32'd1);
        chk("b2b_slt_rd",     {27'd0, O_rd},    32'd3);
        issue(4'd9, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1);
        chk("sltu_result", O_result,        32'd0);
        chk("sltu_zero",   {31'd0, O_zero}, 32'd1);

        // 3: shifts and immediate operand
        issue(4'd7, 32'h8000_0000, 32'd36, 32'd0, 1'b0, 5'd5, 1'b1);
        chk("sra_result", O_result, 32'hF800_0000);
        issue(4'd6, 32'h8000_0000, 32'd36, 32'd0, 1'b0, 5'd5, 1'b1);
        chk("srl_result", O_result, 32'h0800_0000);
        issue(4'd5, 32'h0000_0003, 32'd0, 32'd33, 1'b1, 5'd5, 1'b1);
        chk("sll_imm_result", O_result, 32'h0000_0006);
        issue(4'd1, 32'd5, 32'd99, 32'd5, 1'b1, 5'd6, 1'b1);
        chk("subimm_result", O_result,        32'd0);
        chk("subimm_zero",   {31'd0, O_zero}, 32'd1);
        issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 5'd6, 1'b1);
        chk("and_result", O_result, 32'hF000_F000);
        issue(4'd3, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'd0, 1'b0, 5'd6, 1'b1);
        chk("or_result", O_result, 32'hFFF0_FFF0);
        issue(4'd4, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'd0, 1'b0, 5'd6, 1'b1);
        chk("xor_result", O_result, 32'h0F0F_F0F0);
        issue(4'd11, 32'd1, 32'd2, 32'h1234_5678, 1'b1, 5'd6, 1'b1);
        chk("passb_result", O_result, 32'h1234_5678);

        // 4: MUL with a stray ADD pulsed mid-operation
        issue(4'd10, 32'd1000, 32'd10011, 32'd0, 1'b0, 5'd8, 1'b1);
        low_cnt = 0;
        vld_cnt = 0;
        for (int i = 1; i <= 32; i++) begin
            if (O_ready == 1'b0) low_cnt++;
            if (O_valid == 1'b1) vld_cnt++;
            if (i == 6) begin
                I_aluop = 4'd0; I_dataA = 32'd1; I_dataB = 32'd1; I_rd = 5'd9;
                I_valid = 1'b1;
            end else begin
                I_valid = 1'b0;
            end
            I_dataA = 32'hDEAD_BEEF;
            tick();
        end
        I_valid = 1'b0;
        chk("mul_ready_low_cycles", low_cnt, 32'd32);
        chk("mul_no_early_valid",   vld_cnt, 32'd0);
        chk("mul_valid",  {31'd0, O_valid}, 32'd1);
        chk("mul_result", O_result,         32'd10011000);
        chk("mul_rd",     {27'd0, O_rd},    32'd8);
        chk("mul_regwe",  {31'd0, O_regwe}, 32'd1);
        chk("mul_ready",  {31'd0, O_ready}, 32'd1);
        // Accept an ADD in the MUL's valid cycle
        issue(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 5'd10, 1'b1);
        chk("post_mul_add_valid",  {31'd0, O_valid}, 32'd1);
        chk("post_mul_add_result", O_result,         32'd42);

        issue(4'd10, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd11, 1'b1);
        for (int i = 0; i < 32; i++) tick();
        chk("mul2_valid",  {31'd0, O_valid}, 32'd1);
        chk("mul2_result", O_result,         32'hFFFF_FFFE);

        // 5: reset during MUL iteration 10
        issue(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 5'd12, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        chk("mrst_valid",  {31'd0, O_valid}, 32'd0);
        chk("mrst_result", O_result,         32'd0);
        chk("mrst_rd",     {27'd0, O_rd},    32'd0);
        chk("mrst_regwe",  {31'd0, O_regwe}, 32'd0);
        chk("mrst_zero",   {31'd0, O_zero},  32'd0);
        chk("mrst_ready",  {31'd0, O_ready}, 32'd1);
        vld_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (O_valid == 1'b1) vld_cnt++;
        end
        chk("mrst_no_valid", vld_cnt, 32'd0);
        issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd9, 1'b1);
        chk("mrst_add_valid",  {31'd0, O_valid}, 32'd1);
        chk("mrst_add_result", O_result,         32'd5);
        chk("mrst_add_rd",     {27'd0, O_rd},    32'd9);

        // 6: x0 write suppression and illegal opcode
        issue(4'd0, 32'd4, 32'd4, 32'd0, 1'b0, 5'd0, 1'b1);
        chk("x0_valid",  {31'd0, O_valid}, 32'd1);
        chk("x0_regwe",  {31'd0, O_regwe}, 32'd0);
        chk("x0_result", O_result,         32'd8);
        issue(4'd15, 32'd4, 32'd4, 32'd0, 1'b0, 5'd4, 1'b1);
        chk("ill_valid",  {31'd0, O_valid}, 32'd1);
        chk("ill_result", O_result,         32'd0);
        chk("ill_regwe",  {31'd0, O_regwe}, 32'd0);
        chk("ill_rd",     {27'd0, O_rd},    32'd4);
        issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd4, 1'b0);
        chk("noregwe_regwe", {31'd0, O_regwe}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the register file (Reg_Re).
- Consumes the two read operands (O_dataA/O_dataB) plus decoded op, immediate and destination.
- Produces a registered result with rd/write-enable, which feeds the register-file write port (I_dataD, I_rd, I_en) through writeback.
- Single-cycle ALU ops; iterative shift-add MUL that stalls upstream via O_ready.

Parameters:
- XLEN, 32, datapath width. Only 32 is verified.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- I_rst  in  1  synchronous active-high reset.
- I_valid  in  1  op and operands valid this cycle.
- O_ready  out  1  stage can accept an op this cycle.
- I_aluop  in  4  operation select.
- I_dataA  in  XLEN  operand A, from register file O_dataA.
- I_dataB  in  XLEN  operand B, from register file O_dataB.
- I_imm  in  XLEN  sign-extended immediate.
- I_useimm  in  1  1: operand B = I_imm; 0: operand B = I_dataB.
- I_rd  in  RA_W  destination register.
- I_regwe  in  1  instruction writes rd.
- O_valid  out  1  one-cycle pulse: result valid.
- O_result  out  XLEN  result.
- O_rd  out  RA_W  destination, aligned with O_result.
- O_regwe  out  1  register-file write enable, aligned with O_valid.
- O_zero  out  1  O_result == 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; O_valid, O_result, O_rd, O_regwe, O_zero = 0; O_ready=1 in the cycle after the reset edge.
- Reset mid-MUL aborts the operation; no O_valid is produced for it.
- Accept: an op is accepted on the rising edge where I_valid && O_ready. O_ready = (state==IDLE).
- I_valid while O_ready=0 is ignored. Upstream holds the op until it is accepted.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low XLEN bits), 11 PASSB.
- Illegal opcodes 12-15: O_result=0, O_valid=1, O_regwe=0.
- Operand B = I_useimm ? I_imm : I_dataB.
- Shift amount = B[4:0]; upper bits of B are ignored.
- All arithmetic wraps modulo 2^XLEN. SLT/SLTU produce 1 or 0, zero-extended.
- Single-cycle ops:
  - Op accepted at edge k: O_valid=1 in the cycle after edge k, with O_result/O_rd/O_zero updated at that edge.
  - State stays IDLE, so back-to-back accepts every cycle give back-to-back O_valid pulses.
- MUL FSM, states IDLE and MUL:
  - At the accept edge: acc=0, mcand=A, mplier=B, cnt=31, state->MUL.
  - Each edge in MUL: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt--.
  - On the edge where cnt==0: O_result = final acc, O_valid=1, state->IDLE.
  - Timing: accept at edge k, O_valid high in the cycle after edge k+32. O_ready is low for exactly 32 cycles.
  - The next op can be accepted at edge k+33, the cycle in which the MUL's O_valid is high.
- O_regwe = O_valid && latched I_regwe && legal op && O_rd!=0. Writes to x0 are suppressed; O_valid still pulses.
- O_valid is low in all other cycles.
- O_result, O_rd and O_zero hold their last values between O_valid pulses.
- Operands are latched at accept. Input changes during MUL do not affect the result.

Test Plan:
1. ADD, A=1000, B=10001, rd=7, regwe=1 -> next cycle O_valid=1, O_result=11001, O_rd=7, O_regwe=1, O_zero=0. One-cycle pulse only.
2. SUB 5-7 -> 0xFFFFFFFE; SLT(-2,1) -> 1; SLTU(0xFFFFFFFE,1) -> 0. Issue ADD, SUB, SLT on consecutive cycles -> three consecutive O_valid pulses, in order.
3. SRA 0x80000000 by B=36 -> 0xF8000000 (shift 4); SRL same operands -> 0x08000000; SUB 5-5 with useimm=1, imm=5 -> O_result=0, O_zero=1.
4. MUL 1000*10011 -> O_result=10011000 exactly 32 cycles after accept; O_ready low for those 32 cycles; an ADD pulsed on I_valid mid-MUL is ignored. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
5. I_rst=1 for one cycle at MUL iteration 10 -> after that edge all outputs 0, O_ready=1, no O_valid afterwards; a subsequent ADD completes normally.
6. ADD with rd=0 -> O_valid=1, O_regwe=0. Opcode 15, rd=4, regwe=1 -> O_valid=1, O_result=0, O_regwe=0.
